// File: rtl/fixed_point_add_arbiter.sv
// fixed_point_add_arbiter
// Round-robin front end that shares one combinational sign-magnitude adder
// among NUM_REQ requesters. One request is granted per cycle, its operands are
// steered onto the shared adder, and the sum is captured in a single-entry
// result register that is handed out over a valid/ready response port.
//
// Operand format: bit 15 = sign, [14:8] = integer, [7:0] = fraction.
// Subtraction is performed by flipping the sign bit of operand b before it
// reaches the adder. A negative-zero sum (16'h8000) is stored as 16'h0000 so
// consumers only ever see one encoding of zero.

module fixed_point_add_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_sub,
    output logic [15:0]            add_a,
    output logic [15:0]            add_b,
    input  logic [15:0]            add_c,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            op_count
);

    // Result-register occupancy: EMPTY means nothing to hand out.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [15:0]       r_rsp_data;
    logic [ID_W-1:0]   r_rsp_id;
    logic [15:0]       r_op_count;

    logic              w_can_accept;
    logic              w_found;
    logic [ID_W-1:0]   w_idx;
    logic              w_grant;
    logic [15:0]       w_sel_a;
    logic [15:0]       w_sel_b;
    logic              w_sel_sub;

    // Collapse negative zero onto the single canonical zero encoding.
    function automatic logic [15:0] norm_zero(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'h8000) begin
            r = 16'h0000;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Negate a sign-magnitude value by inverting only its sign bit.
    function automatic logic [15:0] flip_sign(input logic [15:0] v);
        return {~v[15], v[14:0]};
    endfunction

    // Priority pointer moves to the requester just after the one served.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] i);
        logic [ID_W-1:0] r;
        if (i == ID_W'(NUM_REQ - 1)) begin
            r = {ID_W{1'b0}};
        end else begin
            r = i + ID_W'(1);
        end
        return r;
    endfunction

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign op_count  = r_op_count;

    // A new result fits when the register is empty or is being drained now.
    // Reset blocks acceptance so no requester sees a handshake that is dropped.
    assign w_can_accept = (~rst) & ((r_state == ST_EMPTY) | (rsp_valid & rsp_ready));

    // Round-robin scan starting at the priority pointer.
    always_comb begin : rr_scan
        int j;
        w_found = 1'b0;
        w_idx   = {ID_W{1'b0}};
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end else begin
                j = j;
            end
            if (!w_found && req_valid[j]) begin
                w_found = 1'b1;
                w_idx   = ID_W'(j);
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_grant = w_found & w_can_accept;

    // One-hot accept towards the granted requester, zero otherwise.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (w_grant) begin
            req_ready[w_idx] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Operand selection for the granted requester.
    always_comb begin
        w_sel_a   = req_a[int'(w_idx)*16 +: 16];
        w_sel_b   = req_b[int'(w_idx)*16 +: 16];
        w_sel_sub = req_sub[w_idx];
    end

    // Drive the shared adder; idle value is zero so it never toggles needlessly.
    always_comb begin
        add_a = 16'h0000;
        add_b = 16'h0000;
        if (w_grant) begin
            add_a = w_sel_a;
            if (w_sel_sub) begin
                add_b = flip_sign(w_sel_b);
            end else begin
                add_b = w_sel_b;
            end
        end else begin
            add_a = 16'h0000;
            add_b = 16'h0000;
        end
    end

    // Next-state logic for the result-register occupancy.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end else if (rsp_ready) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register; reset discards any result still in the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture result, owner, priority and count on every accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data <= 16'h0000;
            r_rsp_id   <= {ID_W{1'b0}};
            r_ptr      <= {ID_W{1'b0}};
            r_op_count <= 16'h0000;
        end else if (w_grant) begin
            r_rsp_data <= norm_zero(add_c);
            r_rsp_id   <= w_idx;
            r_ptr      <= next_ptr(w_idx);
            r_op_count <= r_op_count + 16'h0001;
        end else begin
            r_rsp_data <= r_rsp_data;
            r_rsp_id   <= r_rsp_id;
            r_ptr      <= r_ptr;
            r_op_count <= r_op_count;
        end
    end

endmodule
